// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the bypassing register file.
//   REGFILE_WIDTH  - default data width in bits
//   REGFILE_ADDR_W - default address width
//   regfile_depth  - number of registers for a given address width
package regfile_pkg;

    localparam int REGFILE_WIDTH  = 16;
    localparam int REGFILE_ADDR_W = 3;

    function automatic int regfile_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the register file.
//   active            - high when the file is out of reset; low forces zero outputs
//   addr              - register being read
//   regs, pending     - stored register values and scoreboard bits
//   wa_*, wb_*        - this cycle's writeback ports, used for forwarding
//   rd_data, rd_busy  - read value and "operand still in flight" flag
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH   = REGFILE_WIDTH,
    parameter int ADDR_W  = REGFILE_ADDR_W,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int DEPTH  = regfile_depth(ADDR_W)
) (
    input  logic              active,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  regs [DEPTH],
    input  logic [DEPTH-1:0]  pending,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [WIDTH-1:0]  wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_busy
);

    localparam bit BYP = (BYPASS != 0);
    localparam bit ZR  = (ZERO_R0 != 0);

    logic hit_a;
    logic hit_b;

    assign hit_a = BYP && wa_en && (wa_addr == addr);
    assign hit_b = BYP && wb_en && (wb_addr == addr);

    always_comb begin
        rd_data = regs[addr];
        rd_busy = pending[addr];
        if (!active || (ZR && (addr == '0))) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else begin
            // Port A is the younger result, so it shadows port B on a collision.
            if (hit_a) begin
                rd_data = wa_data;
            end else if (hit_b) begin
                rd_data = wb_data;
            end
            // A load landing this cycle resolves the operand, even if A also writes it.
            rd_busy = pending[addr] && !hit_b;
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: two-write, two-read register file with write-to-read
// forwarding and a per-register pending scoreboard for in-flight loads.
//   clk, reset                  - clock, asynchronous active-low reset
//   rd_addr1/2 -> rd_data1/2    - combinational read ports
//   rd_busy1/2                  - addressed register still waiting on a load
//   wa_en/addr/data             - execute writeback (wins on address collision)
//   wb_en/addr/data             - load writeback, clears the pending bit
//   claim_en/addr               - decode marks a load destination as pending
//   pending                     - scoreboard vector, one bit per register
//   wr_conflict                 - both write ports target the same register
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH   = REGFILE_WIDTH,
    parameter int ADDR_W  = REGFILE_ADDR_W,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int DEPTH  = regfile_depth(ADDR_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [WIDTH-1:0]  wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic [DEPTH-1:0]  pending,
    output logic              wr_conflict
);

    localparam bit ZR = (ZERO_R0 != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    always_comb begin
        regs_d = regs_q;
        // B is applied first so a same-address A write overrides it.
        if (wb_en && !(ZR && (wb_addr == '0))) begin
            regs_d[wb_addr] = wb_data;
        end
        if (wa_en && !(ZR && (wa_addr == '0))) begin
            regs_d[wa_addr] = wa_data;
        end
    end

    always_comb begin
        pending_d = pending_q;
        // Clear first, then set: a claim beats a completing load at the same register.
        if (wb_en) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (claim_en) begin
            pending_d[claim_addr] = 1'b1;
        end
        if (ZR) begin
            pending_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    assign pending     = pending_q;
    assign wr_conflict = reset && wa_en && wb_en && (wa_addr == wb_addr);

    regfile_read_port #(
        .WIDTH   (WIDTH),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_rd1 (
        .active  (reset),
        .addr    (rd_addr1),
        .regs    (regs_q),
        .pending (pending_q),
        .wa_en   (wa_en),
        .wa_addr (wa_addr),
        .wa_data (wa_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .rd_data (rd_data1),
        .rd_busy (rd_busy1)
    );

    regfile_read_port #(
        .WIDTH   (WIDTH),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_rd2 (
        .active  (reset),
        .addr    (rd_addr2),
        .regs    (regs_q),
        .pending (pending_q),
        .wa_en   (wa_en),
        .wa_addr (wa_addr),
        .wa_data (wa_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .rd_data (rd_data2),
        .rd_busy (rd_busy2)
    );

endmodule
